cmd_seq_multi: RTL and testbench
================================

// Module: cmd_seq_multi
// PURPOSE
//  Parametrised multi-channel serial command sequencer for FE command links, single clock domain.
//  Bus-programmed byte memory holds a bit pattern that is streamed MSB-first on up to 8 masked channels.
//  Supports start offset, repeat count with inter-repetition gap, infinite mode, abort and an external start.
//  Bit rate is set by a BUS_CLK-synchronous clock enable. Sits behind the bus decoder like other slave cores.
// PARAMETERS
//  MEM_BYTES  2048  command memory depth in bytes; power of 2, 16..32768
//  CHANNELS   4     number of CMD_DATA outputs, 1..8
//  VERSION    1     value returned on read of address 0
// PORTS
//  BUS_CLK           in   1         clock, all logic on posedge
//  RST               in   1         reset, synchronous, active-high
//  BUS_ADD           in   16        local byte address
//  BUS_DATA_IN       in   8         write data
//  BUS_RD            in   1         read strobe
//  BUS_WR            in   1         write strobe, one cycle per byte
//  BUS_DATA_OUT      out  8         read data, registered, valid the cycle after BUS_RD
//  BIT_CE            in   1         sequencer advances one bit only on edges with BIT_CE=1
//  EXT_START         in   1         external start request, level sampled each edge
//  EXT_START_ENABLE  out  1         mirror of CONF[0]
//  CMD_DATA          out  CHANNELS  serial data; channel ch = current bit AND CH_EN[ch]
//  CMD_READY         out  1         1 when IDLE
//  CMD_DONE          out  1         one-cycle pulse on normal completion; no pulse on abort or reset
// BEHAVIOUR
//  Register map:
//   0       W: soft reset, any data; R: VERSION
//   1       W: start; R: {7'b0,READY}
//   2       CONF: [0] EN_EXT_START, [1] INFINITE
//   3-4     CMD_SIZE in bits, LSB first
//   5-6     REPEAT_COUNT
//   7-8     REPEAT_DELAY in bit ticks
//   9-10    START_BYTE
//   11      CH_EN[CHANNELS-1:0]; upper bits read back 0
//   12      W: stop/abort
//   13-14   R: repetitions completed, saturates at 16'hffff
//   15      reserved, reads 0
//   16..16+MEM_BYTES-1   command memory; reads/writes outside this range read 0 and are ignored
//  Register reset: all 0 except REPEAT_COUNT=1 and CH_EN=all ones. Memory is not cleared.
//  Soft reset behaves exactly as RST one edge after the write.
//  Output reset: CMD_DATA=0, CMD_READY=1, CMD_DONE=0, BUS_DATA_OUT=0.
//  FSM:
//   IDLE->SEND on start write or (EXT_START & EN_EXT_START), only if CMD_SIZE!=0; otherwise stays IDLE.
//   SEND: bit b of CMD_SIZE reads mem[(START_BYTE + b/8) mod MEM_BYTES] bit 7-(b%8).
//   SEND end of repetition: ->GAP if REPEAT_DELAY!=0 and more repetitions remain; ->SEND if REPEAT_DELAY=0; else ->IDLE with CMD_DONE.
//   GAP: CMD_DATA=0 for REPEAT_DELAY bit ticks, then ->SEND.
//  Start latches CMD_SIZE, REPEAT_COUNT, REPEAT_DELAY, START_BYTE; CH_EN and INFINITE are live.
//  REPEAT_COUNT=0 is treated as 1. INFINITE=1 repeats until stop.
//  Latency (BIT_CE=1): start write at edge k -> READY=0 after k+1.
//   Bit 0 on CMD_DATA after edge k+2; last bit after edge k+1+CMD_SIZE*N plus gaps.
//   CMD_DATA=0 and READY=1 one edge later.
//  CMD_DONE pulses in the same cycle READY returns to 1.
//  Start or ext start while not IDLE is ignored.
//  Stop write: next edge -> IDLE, CMD_DATA=0, no CMD_DONE.
//  RST mid-send: immediate IDLE, outputs to reset values.
//  Memory write during SEND is allowed; a byte is sampled one tick before its first bit.
//  Repetition counter clears on start and increments at each completed repetition.
//  Count wraps are not allowed; it saturates.
// TESTING
//  1 mem[0]=8'hA5, CMD_SIZE=8, BIT_CE=1, start -> CMD_DATA[0]=1,0,1,0,0,1,0,1 from edge k+2; CMD_DONE once; READY=1.
//  2 CMD_SIZE=12, REPEAT_COUNT=3, REPEAT_DELAY=4 -> 3x12 bits separated by 4 zero ticks; reg 13-14 reads 3.
//  3 START_BYTE=MEM_BYTES-1, CMD_SIZE=16 -> second byte fetched from address 0 (wrap).
//  4 INFINITE=1, stop write after 100 cycles -> CMD_DATA=0 next edge, READY=1, no CMD_DONE.
//  5 CH_EN=4'b0101, pattern 8'hFF -> CMD_DATA=4'b0101 for 8 bits; EXT_START ignored while EN_EXT_START=0.
//  6 BIT_CE every 4th edge, CMD_SIZE=0 start -> stays IDLE; CMD_SIZE=8 -> each bit held 4 cycles; RST mid-send -> reset values.

Source files
------------

// File: rtl/cmd_seq_multi.sv
// cmd_seq_multi: bus-programmed multi-channel serial command sequencer streaming a byte-memory pattern MSB-first.
module cmd_seq_multi #(
  parameter int MEM_BYTES = 2048,
  parameter int CHANNELS  = 4,
  parameter int VERSION   = 1
) (
  input  logic                BUS_CLK,
  input  logic                RST,
  input  logic [15:0]         BUS_ADD,
  input  logic [7:0]          BUS_DATA_IN,
  input  logic                BUS_RD,
  input  logic                BUS_WR,
  output logic [7:0]          BUS_DATA_OUT,
  input  logic                BIT_CE,
  input  logic                EXT_START,
  output logic                EXT_START_ENABLE,
  output logic [CHANNELS-1:0] CMD_DATA,
  output logic                CMD_READY,
  output logic                CMD_DONE
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [7:0] VER = 8'(VERSION);
  localparam logic [16:0] MEM_END = 17'(16 + MEM_BYTES);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;
  logic [7:0] mem [MEM_BYTES];
  logic [7:0] seq_byte_q;
  logic [1:0] state_q, state_d, conf_q, conf_d;
  logic [15:0] b_q, b_d, g_q, g_d, reps_q, reps_d;
  logic [15:0] size_q, size_d, rcnt_q, rcnt_d, rdly_q, rdly_d, sbyte_q, sbyte_d;
  logic [15:0] l_size_q, l_size_d, l_rcnt_q, l_rcnt_d, l_rdly_q, l_rdly_d, l_sb_q, l_sb_d;
  logic [CHANNELS-1:0] chen_q, chen_d;
  logic [7:0] rdata_q, rdata_d;
  logic bit_q, bit_d, done_q, done_d, start_q, start_d, stop_q, stop_d, srst_q, srst_d;
  logic in_mem, go, more, rd_bit;
  logic [AW-1:0] bus_a, seq_a;
  logic [15:0] e_cur, e_nxt, reps_eff, reps_inc;
  assign in_mem = ({1'b0, BUS_ADD} >= 17'd16) && ({1'b0, BUS_ADD} < MEM_END);
  assign bus_a = AW'(BUS_ADD - 16'd16);
  // The byte feeding the next emitted bit is read one edge ahead, so it tracks the post-edge state.
  assign e_cur = (state_q == SEND && b_q < l_size_q) ? b_q : 16'd0;
  assign e_nxt = (state_d == SEND && b_d < l_size_d) ? b_d : 16'd0;
  assign seq_a = AW'(l_sb_d + (e_nxt >> 3));
  assign rd_bit = seq_byte_q[~e_cur[2:0]];
  assign go = start_q | (EXT_START & conf_q[0]);
  assign reps_eff = (l_rcnt_q == 16'd0) ? 16'd1 : l_rcnt_q;
  assign more = conf_q[1] | (({1'b0, reps_q} + 17'd1) < {1'b0, reps_eff});
  assign reps_inc = (&reps_q) ? reps_q : reps_q + 16'd1;
  assign CMD_DATA = {CHANNELS{bit_q}} & chen_q;
  assign CMD_READY = state_q == IDLE;
  assign CMD_DONE = done_q;
  assign EXT_START_ENABLE = conf_q[0];
  assign BUS_DATA_OUT = rdata_q;
  always_comb begin
    rdata_d = rdata_q;
    if (BUS_RD) begin
      rdata_d = 8'd0;
      if (in_mem) rdata_d = mem[bus_a];
      else case (BUS_ADD)
        16'd0:  rdata_d = VER;
        16'd1:  rdata_d = {7'd0, state_q == IDLE};
        16'd2:  rdata_d = {6'd0, conf_q};
        16'd3:  rdata_d = size_q[7:0];
        16'd4:  rdata_d = size_q[15:8];
        16'd5:  rdata_d = rcnt_q[7:0];
        16'd6:  rdata_d = rcnt_q[15:8];
        16'd7:  rdata_d = rdly_q[7:0];
        16'd8:  rdata_d = rdly_q[15:8];
        16'd9:  rdata_d = sbyte_q[7:0];
        16'd10: rdata_d = sbyte_q[15:8];
        16'd11: rdata_d = 8'(chen_q);
        16'd13: rdata_d = reps_q[7:0];
        16'd14: rdata_d = reps_q[15:8];
        default: rdata_d = 8'd0;
      endcase
    end
  end
  always_comb begin
    {srst_d, start_d, stop_d} = 3'b000;
    conf_d = conf_q;
    size_d = size_q;
    rcnt_d = rcnt_q;
    rdly_d = rdly_q;
    sbyte_d = sbyte_q;
    chen_d = chen_q;
    if (BUS_WR) case (BUS_ADD)
      16'd0:  srst_d = 1'b1;
      16'd1:  start_d = 1'b1;
      16'd2:  conf_d = BUS_DATA_IN[1:0];
      16'd3:  size_d[7:0] = BUS_DATA_IN;
      16'd4:  size_d[15:8] = BUS_DATA_IN;
      16'd5:  rcnt_d[7:0] = BUS_DATA_IN;
      16'd6:  rcnt_d[15:8] = BUS_DATA_IN;
      16'd7:  rdly_d[7:0] = BUS_DATA_IN;
      16'd8:  rdly_d[15:8] = BUS_DATA_IN;
      16'd9:  sbyte_d[7:0] = BUS_DATA_IN;
      16'd10: sbyte_d[15:8] = BUS_DATA_IN;
      16'd11: chen_d = BUS_DATA_IN[CHANNELS-1:0];
      16'd12: stop_d = 1'b1;
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    b_d = b_q;
    g_d = g_q;
    bit_d = bit_q;
    done_d = 1'b0;
    reps_d = reps_q;
    l_size_d = l_size_q;
    l_rcnt_d = l_rcnt_q;
    l_rdly_d = l_rdly_q;
    l_sb_d = l_sb_q;
    if (stop_q) begin
      state_d = IDLE;
      bit_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (go && size_q != 16'd0) begin
        state_d = SEND;
        b_d = 16'd0;
        reps_d = 16'd0;
        l_size_d = size_q;
        l_rcnt_d = rcnt_q;
        l_rdly_d = rdly_q;
        l_sb_d = sbyte_q;
      end
    end else if (BIT_CE) begin
      if (state_q == GAP) begin
        if (g_q >= l_rdly_q) begin
          state_d = SEND;
          bit_d = rd_bit;
          b_d = 16'd1;
        end else begin
          g_d = g_q + 16'd1;
          bit_d = 1'b0;
        end
      end else if (b_q < l_size_q) begin
        bit_d = rd_bit;
        b_d = b_q + 16'd1;
      end else begin
        // End of repetition: this tick either starts the next one, opens the gap, or finishes.
        reps_d = reps_inc;
        if (!more) begin
          state_d = IDLE;
          bit_d = 1'b0;
          done_d = 1'b1;
        end else if (l_rdly_q == 16'd0) begin
          bit_d = rd_bit;
          b_d = 16'd1;
        end else begin
          state_d = GAP;
          g_d = 16'd1;
          bit_d = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge BUS_CLK) begin
    if (BUS_WR && in_mem) mem[bus_a] <= BUS_DATA_IN;
    seq_byte_q <= mem[seq_a];
  end
  always_ff @(posedge BUS_CLK) begin
    if (RST || srst_q) begin
      state_q <= IDLE;
      {b_q, g_q, reps_q} <= '0;
      {bit_q, done_q, start_q, stop_q, srst_q} <= '0;
      conf_q <= 2'd0;
      size_q <= 16'd0;
      rcnt_q <= 16'd1;
      rdly_q <= 16'd0;
      sbyte_q <= 16'd0;
      chen_q <= {CHANNELS{1'b1}};
      {l_size_q, l_rcnt_q, l_rdly_q, l_sb_q} <= '0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      b_q <= b_d;
      g_q <= g_d;
      reps_q <= reps_d;
      bit_q <= bit_d;
      done_q <= done_d;
      start_q <= start_d;
      stop_q <= stop_d;
      srst_q <= srst_d;
      conf_q <= conf_d;
      size_q <= size_d;
      rcnt_q <= rcnt_d;
      rdly_q <= rdly_d;
      sbyte_q <= sbyte_d;
      chen_q <= chen_d;
      l_size_q <= l_size_d;
      l_rcnt_q <= l_rcnt_d;
      l_rdly_q <= l_rdly_d;
      l_sb_q <= l_sb_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_cmd_seq_multi.sv
// tb_cmd_seq_multi: directed self-checking bench for cmd_seq_multi with default parameters.
module tb_cmd_seq_multi;
  logic BUS_CLK = 1'b0, RST = 1'b1, BUS_RD = 1'b0, BUS_WR = 1'b0, BIT_CE, EXT_START = 1'b0;
  logic [15:0] BUS_ADD = 16'd0;
  logic [7:0] BUS_DATA_IN = 8'd0, BUS_DATA_OUT;
  logic EXT_START_ENABLE, CMD_READY, CMD_DONE;
  logic [3:0] CMD_DATA;
  int n_cmp = 0, n_bad = 0, dones = 0, cecnt = 0;
  logic slow = 1'b0;
  cmd_seq_multi dut (
    .BUS_CLK(BUS_CLK), .RST(RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_RD(BUS_RD), .BUS_WR(BUS_WR), .BUS_DATA_OUT(BUS_DATA_OUT), .BIT_CE(BIT_CE),
    .EXT_START(EXT_START), .EXT_START_ENABLE(EXT_START_ENABLE), .CMD_DATA(CMD_DATA),
    .CMD_READY(CMD_READY), .CMD_DONE(CMD_DONE)
  );
  always #5 BUS_CLK = ~BUS_CLK;
  always @(negedge BUS_CLK) begin
    BIT_CE = !slow || (cecnt % 4 == 0);
    cecnt++;
  end
  always @(posedge BUS_CLK) if (CMD_DONE === 1'b1) dones++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    BUS_ADD = a;
    BUS_DATA_IN = d;
    BUS_WR = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR = 1'b0;
  endtask
  task automatic wr16(input logic [15:0] a, input logic [15:0] d);
    wr(a, d[7:0]);
    wr(a + 16'd1, d[15:8]);
  endtask
  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    BUS_ADD = a;
    BUS_RD = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD = 1'b0;
    d = BUS_DATA_OUT;
  endtask
  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] r;
    rd(a, r);
    check(tag, r, exp);
  endtask
  task automatic start();
    wr(16'd1, 8'd0);
    @(negedge BUS_CLK);
  endtask
  task automatic cap(input int n, input bit all, output logic [63:0] v);
    v = '0;
    repeat (n) begin
      @(negedge BUS_CLK);
      v = all ? {v[59:0], CMD_DATA} : {v[62:0], CMD_DATA[0]};
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] v;
    int d0, t;
    repeat (3) @(negedge BUS_CLK);
    RST = 1'b0;
    check("rst_ready", CMD_READY, 1);
    check("rst_data", CMD_DATA, 0);
    check("rst_done", CMD_DONE, 0);
    check("rst_busout", BUS_DATA_OUT, 0);
    rd_chk("version", 16'd0, 8'd1);
    rd_chk("rst_rcnt_lo", 16'd5, 8'd1);
    rd_chk("rst_rcnt_hi", 16'd6, 8'd0);
    rd_chk("rst_chen", 16'd11, 8'h0F);
    rd_chk("rst_ready_reg", 16'd1, 8'd1);
    rd_chk("reserved", 16'd15, 8'd0);
    // single 8-bit shot of A5 on all enabled channels
    wr(16'd16, 8'hA5);
    wr16(16'd3, 16'd8);
    d0 = dones;
    start();
    check("t1_busy", CMD_READY, 0);
    check("t1_pre_bit", CMD_DATA, 0);
    cap(8, 1'b1, v);
    check("t1_bits", v[31:0], 32'hF0F00F0F);
    @(negedge BUS_CLK);
    check("t1_ready", CMD_READY, 1);
    check("t1_done", CMD_DONE, 1);
    check("t1_idle_data", CMD_DATA, 0);
    @(negedge BUS_CLK);
    check("t1_done_once", CMD_DONE, 0);
    check("t1_done_cnt", dones - d0, 1);
    // three 12-bit repetitions with 4-tick gaps
    wr(16'd17, 8'h3C);
    wr16(16'd3, 16'd12);
    wr16(16'd5, 16'd3);
    wr16(16'd7, 16'd4);
    d0 = dones;
    start();
    cap(44, 1'b0, v);
    check("t2_stream", v[43:0], 44'hA530A530A53);
    @(negedge BUS_CLK);
    check("t2_ready", CMD_READY, 1);
    @(negedge BUS_CLK);
    check("t2_done_cnt", dones - d0, 1);
    rd_chk("t2_reps_lo", 16'd13, 8'd3);
    rd_chk("t2_reps_hi", 16'd14, 8'd0);
    // start at the last byte, second byte wraps to address 0
    wr16(16'd5, 16'd1);
    wr16(16'd7, 16'd0);
    wr(16'd2063, 8'h5A);
    wr16(16'd9, 16'd2047);
    wr16(16'd3, 16'd16);
    start();
    cap(16, 1'b0, v);
    check("t3_wrap", v[15:0], 16'h5AA5);
    @(negedge BUS_CLK);
    check("t3_ready", CMD_READY, 1);
    // infinite mode, stopped by the abort register
    wr16(16'd9, 16'd0);
    wr16(16'd3, 16'd8);
    wr(16'd2, 8'd2);
    d0 = dones;
    start();
    repeat (100) @(negedge BUS_CLK);
    check("t4_busy", CMD_READY, 0);
    wr(16'd12, 8'd0);
    check("t4_stop_pending", CMD_READY, 0);
    @(negedge BUS_CLK);
    check("t4_stop_data", CMD_DATA, 0);
    check("t4_stop_ready", CMD_READY, 1);
    repeat (2) @(negedge BUS_CLK);
    check("t4_no_done", dones - d0, 0);
    rd_chk("t4_reps", 16'd13, 8'd12);
    wr(16'd2, 8'd0);
    // channel mask and external start gating
    wr(16'd24, 8'hFF);
    wr16(16'd9, 16'd8);
    wr(16'd11, 8'h05);
    EXT_START = 1'b1;
    repeat (3) @(negedge BUS_CLK);
    check("t5_ext_ignored", CMD_READY, 1);
    EXT_START = 1'b0;
    wr(16'd2, 8'd1);
    check("t5_ext_en", EXT_START_ENABLE, 1);
    EXT_START = 1'b1;
    @(negedge BUS_CLK);
    EXT_START = 1'b0;
    check("t5_ext_busy", CMD_READY, 0);
    cap(8, 1'b1, v);
    check("t5_mask", v[31:0], 32'h55555555);
    @(negedge BUS_CLK);
    check("t5_ready", CMD_READY, 1);
    wr(16'd2, 8'd0);
    wr(16'd11, 8'h0F);
    // slow bit clock: zero size never starts, then each bit lasts four cycles
    slow = 1'b1;
    wr16(16'd3, 16'd0);
    wr16(16'd9, 16'd0);
    d0 = dones;
    wr(16'd1, 8'd0);
    repeat (6) @(negedge BUS_CLK);
    check("t6_size0_idle", CMD_READY, 1);
    check("t6_size0_no_done", dones - d0, 0);
    wr16(16'd3, 16'd8);
    wr(16'd1, 8'd0);
    t = 0;
    while (CMD_DATA[0] !== 1'b1 && t < 16) begin
      @(negedge BUS_CLK);
      t++;
    end
    check("t6_first_bit", CMD_DATA[0], 1);
    cap(31, 1'b0, v);
    check("t6_hold4", {1'b1, v[30:0]}, 32'hF0F00F0F);
    repeat (8) @(negedge BUS_CLK);
    start();
    repeat (10) @(negedge BUS_CLK);
    check("t6_busy", CMD_READY, 0);
    RST = 1'b1;
    @(negedge BUS_CLK);
    RST = 1'b0;
    check("t6_rst_data", CMD_DATA, 0);
    check("t6_rst_ready", CMD_READY, 1);
    check("t6_rst_done", CMD_DONE, 0);
    check("t6_rst_busout", BUS_DATA_OUT, 0);
    rd_chk("t6_rst_size", 16'd3, 8'd0);
    rd_chk("t6_rst_chen", 16'd11, 8'h0F);
    slow = 1'b0;
    // soft reset restores register defaults
    wr(16'd11, 8'h03);
    rd_chk("srst_pre", 16'd11, 8'h03);
    wr(16'd0, 8'd0);
    @(negedge BUS_CLK);
    rd_chk("srst_chen", 16'd11, 8'h0F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
